// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder processes the operands LSB
// first, one bit per clock, with the carry held in a flop between bits.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_sum, fa_cout;

  full_adder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        // Subtract is a + ~b + 1, so invert B and force the initial carry.
        if (start) begin
          state_d = S_RUN;
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB.
          state_d = S_DONE;
          sum_d   = res_d;
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=2,
// checked against an integer-arithmetic reference model.

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst8_n, rst2_n;
  logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start2, sub2, cin2, busy2, done2, cout2, ovf2;
  logic [1:0] a2, b2, sum2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packed as (sum << 2) | (cout << 1) | ovf.
  function automatic logic [63:0] model(input int w, input longint a, input longint b,
                                        input bit cin, input bit sub);
    longint m, half, bb, full, sa, sb, r;
    logic   ov;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    bb   = sub ? (~b & m) : b;
    full = a + bb + (sub ? 1 : longint'(cin));
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    r    = sub ? sa - sb : sa + sb + longint'(cin);
    ov   = (r < -half) || (r >= half);
    return 64'(((full & m) << 2) | (((full >> w) & 1) << 1) | longint'(ov));
  endfunction

  function automatic logic [63:0] got8();
    return 64'({sum8, cout8, ovf8});
  endfunction

  task automatic rand_in8();
    a8   = 8'($urandom);
    b8   = 8'($urandom);
    cin8 = 1'($urandom);
    sub8 = 1'($urandom);
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input bit cin, input bit sub,
                        input string tag);
    int         lat, nb;
    bit         stable;
    logic [7:0] held;
    logic [63:0] exp;
    exp = model(8, longint'(a), longint'(b), cin, sub);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    held   = sum8;
    rand_in8();
    lat = 0; nb = 0; stable = 1'b1;
    while (!done8 && lat < 40) begin
      if (busy8) nb++;
      if (sum8 !== held) stable = 1'b0;
      lat++;
      @(negedge clk);
      rand_in8();
    end
    check({tag, "_res"}, got8(), exp);
    check({tag, "_lat"}, 64'(lat), 64'd8);
    check({tag, "_busycyc"}, 64'(nb), 64'd8);
    check({tag, "_busy_at_done"}, 64'(busy8), 64'd0);
    check({tag, "_sum_stable"}, 64'(stable), 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done8), 64'd0);
  endtask

  task automatic b2b(input int nops);
    logic [63:0] expq[$];
    logic [7:0]  held;
    int          gap, ndone, guard;
    bit          stable;
    @(negedge clk);
    rand_in8();
    expq.push_back(model(8, longint'(a8), longint'(b8), cin8, sub8));
    start8 = 1'b1;
    held = sum8; gap = 0; ndone = 0; guard = 0; stable = 1'b1;
    while (ndone < nops && guard < nops * 20) begin
      @(negedge clk);
      guard++; gap++;
      if (done8) begin
        check("b2b_res", got8(), (expq.size() > 0) ? expq.pop_front() : 64'hdead);
        check("b2b_gap", 64'(gap), 64'd9);
        gap = 0; ndone++; held = sum8;
        if (ndone < nops) begin
          rand_in8();
          expq.push_back(model(8, longint'(a8), longint'(b8), cin8, sub8));
        end else begin
          start8 = 1'b0;
        end
      end else begin
        if (sum8 !== held) stable = 1'b0;
        rand_in8();
      end
    end
    check("b2b_count", 64'(ndone), 64'(nops));
    check("b2b_stable", 64'(stable), 64'd1);
    @(negedge clk);
  endtask

  task automatic do_op2(input logic [1:0] a, input logic [1:0] b, input bit cin, input bit sub);
    int lat;
    @(negedge clk);
    a2 = a; b2 = b; cin2 = cin; sub2 = sub; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check($sformatf("w2_res_%0d_%0d_%0d_%0d", a, b, cin, sub), 64'({sum2, cout2, ovf2}),
          model(2, longint'(a), longint'(b), cin, sub));
    check("w2_lat", 64'(lat), 64'd2);
  endtask

  initial begin
    int  k;
    bit  saw;
    rst8_n = 1'b0; rst2_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    check("rst8_outs", 64'({busy8, done8, sum8, cout8, ovf8}), 64'd0);
    check("rst2_outs", 64'({busy2, done2, sum2, cout2, ovf2}), 64'd0);
    rst8_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);

    do_op8(8'h35, 8'h4A, 1'b0, 1'b0, "add_35_4a");
    do_op8(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    do_op8(8'h7F, 8'h00, 1'b1, 1'b0, "add_7f_00_c");
    do_op8(8'h10, 8'h20, 1'b0, 1'b1, "sub_10_20");
    do_op8(8'h80, 8'h01, 1'b0, 1'b1, "sub_80_01");
    for (int i = 0; i < 20; i++)
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "rand");

    b2b(6);

    // Ensure a nonzero held result so the async clear is visible.
    do_op8(8'h12, 8'h34, 1'b0, 1'b0, "pre_rst");
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h66; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst8_n = 1'b0;
    #1 check("rst_async", 64'({busy8, done8, sum8, cout8, ovf8}), 64'd0);
    @(negedge clk);
    rst8_n = 1'b1;
    saw = 1'b0;
    for (k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8 || busy8) saw = 1'b1;
    end
    check("rst_no_done", 64'(saw), 64'd0);
    do_op8(8'hC3, 8'h5A, 1'b1, 1'b0, "post_rst");

    for (int sb = 0; sb < 2; sb++)
      for (int c = 0; c < 2; c++)
        for (int x = 0; x < 4; x++)
          for (int y = 0; y < 4; y++)
            do_op2(2'(x), 2'(y), 1'(c), 1'(sb));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer built around one internal FullAdder instance (ports a, b, cin, sum, cout).
- Captures two WIDTH-bit operands on start and feeds the single full adder one bit per clock, LSB first, with a registered carry between bits.
- Presents sum, carry-out and signed overflow with a one-cycle done pulse.
- Used where area matters more than latency; exercises the FullAdder datapath in a sequential context.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- sub  input  1  0 = a+b+cin, 1 = a-b (sampled with start)
- a  input  WIDTH  operand A (sampled with start)
- b  input  WIDTH  operand B (sampled with start)
- cin  input  1  carry-in for add (sampled with start; ignored when sub=1)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result is valid
- sum  output  WIDTH  result, held until the next completion
- cout  output  1  final carry; for subtract, 1 = no borrow
- ovf  output  1  signed overflow: carry into MSB xor carry out of MSB

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, sum, cout and ovf all 0; internal shift registers, bit counter and carry are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN: on an edge with start=1.
  - Latch a into opA.
  - Latch b into opB, or ~b when sub=1.
  - Load the carry register with cin, or 1 when sub=1.
  - Clear the bit counter. Assert busy from the next cycle.
- RUN, each edge:
  - The FullAdder inputs are opA[0], opB[0] and the carry register.
  - Shift the FA sum into the result shift register from the MSB side, so the bit ends at index cnt after WIDTH shifts.
  - Shift opA and opB right by 1.
  - carry <= FA cout. cnt <= cnt+1.
- RUN to DONE: on the edge where cnt==WIDTH-1, i.e. the WIDTH-th RUN edge.
  - Copy the completed result to sum.
  - cout <= FA cout.
  - ovf <= carry register (carry into MSB) xor FA cout.
  - done=1 and busy=0 from the next cycle.
- DONE: done stays high for exactly one cycle.
  - start=1 in DONE goes directly to RUN with the same capture as from IDLE, so back-to-back operations are allowed.
  - Otherwise the next state is IDLE.
- Latency: the start edge is E0; done is high during the cycle after edge E(WIDTH). Minimum issue interval is WIDTH+1 cycles.
- Outputs sum, cout and ovf change only on the completion edge. They are stable during RUN and hold the previous result.
- start while in RUN is ignored, with no queueing. Changes on a, b, cin and sub after capture have no effect.
- Reset mid-RUN aborts immediately. No done is produced, and sum, cout and ovf return to 0.
- Bit counter width is $clog2(WIDTH) and never exceeds WIDTH-1.
- All arithmetic is modulo 2^WIDTH. The subtraction result is the two's complement of a-b.

Test Plan:
- WIDTH=8, add 0x35+0x4A, cin=0 -> sum=0x7F, cout=0, ovf=0; done high exactly in the cycle after the 8th RUN edge; busy high for 8 cycles.
- Add 0xFF+0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Add 0x7F+0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Subtract 0x10-0x20 -> sum=0xF0, cout=0 (borrow), ovf=0. Subtract 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
- Hold start=1 continuously and change a/b mid-RUN:
  - Operations run back-to-back every 9 cycles.
  - Each result matches the operands captured at its own start.
  - sum is stable between done pulses.
- Pull rst_n low asynchronously at the 4th RUN cycle -> busy, done, sum, cout and ovf are 0 immediately; no done follows; the next start completes correctly.
- WIDTH=2, exhaustive over all a, b, cin and sub -> sum, cout and ovf match a behavioural model for all 64 cases.
